counter_4bit: RTL and testbench
===============================

Name: counter_4bit

Overview:
- Free-running binary up-counter with a synchronous count-enable and an asynchronous active-low reset.
- Generic event or cycle counting block. Default width is 4 bits; the counter wraps modulo MAX_VALUE+1.
- Provides a terminal-count flag and a registered wrap pulse so downstream logic can cascade or chain counters.

Parameters:
- WIDTH, 4, bit width of count.
- MAX_VALUE, 2**WIDTH-1, last value before wrapping to 0; legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- enable  input  1  count enable, sampled on rising clk edge; 1 = increment.
- count  output  WIDTH  current count value, registered.
- tc  output  1  terminal count: combinational, 1 when count == MAX_VALUE and enable == 1.
- wrap  output  1  registered one-cycle pulse, 1 in the cycle after count wraps MAX_VALUE -> 0.

Behaviour:
- Reset:
  - reset low forces count = 0 and wrap = 0 asynchronously, with no clock needed.
  - Held while low; tc = 0 during reset because count = 0 (≠ MAX_VALUE).
- Reset release: first increment occurs on the first rising clk edge with reset high and enable high. No synchronizer is inside the block; deassertion is assumed synchronous to clk upstream.
- Counting, on each rising clk edge with reset high:
  - enable = 1 and count < MAX_VALUE: count <= count + 1, wrap <= 0.
  - enable = 1 and count == MAX_VALUE: count <= 0, wrap <= 1.
  - enable = 0: count holds, wrap <= 0.
- Latency: count reflects an increment one clock after enable is sampled high. A continuous enable gives +1 per cycle.
- Arithmetic: unsigned, WIDTH bits. With MAX_VALUE = 2**WIDTH-1, the wrap is the natural modulo-2**WIDTH rollover (default 15 -> 0).
- Pause/resume: deasserting enable freezes count at its current value indefinitely. Reasserting resumes from that value with no skip or repeat.
- Reset mid-count: count drops to 0 at the reset falling edge, independent of clk and enable. Counting restarts from 0 after release if enable is high.
- Simultaneous reset low and enable high: reset wins; count stays 0.
- enable changing exactly at a clk edge is not supported. It must meet setup/hold.
- No X on outputs after the first reset assertion.

Test Plan:
- Reset and hold: reset=0 for 10 ns, enable=0, then reset=1 with enable=0 for 2 cycles -> count=0, tc=0, wrap=0 throughout.
- Continuous count and wrap: enable=1 for 20 rising edges from 0 -> count 1,2,...,15,0,1,2,3,4.
  - tc=1 only while count=15.
  - wrap=1 for exactly the one cycle after 15 -> 0.
- Pause: after reaching count=4, enable=0 for 3 cycles -> count stays 4, wrap=0. Re-enable for 5 edges -> count=9.
- Asynchronous reset mid-run: enable=1, count=9, pull reset low between clk edges -> count=0 immediately, before the next edge.
  - Release reset with enable=1, run 5 edges -> count=5.
- Reset priority: reset=0 with enable=1 across several clk edges -> count stays 0, tc=0, wrap=0.
- Parameter variant: WIDTH=4, MAX_VALUE=9, enable=1 for 12 edges -> count 1..9,0,1,2; wrap pulses once after 9 -> 0.

Source files
------------

// File: rtl/counter_4bit_if.sv
// Counter handshake bundle: enable in, count/tc/wrap out.
interface counter_4bit_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  // The counter's side of the bundle.
  modport slave (
    input  enable,
    output count,
    output tc,
    output wrap
  );

  // The side that drives enable and watches the counter.
  modport master (
    output enable,
    input  count,
    input  tc,
    input  wrap
  );
endinterface

// File: rtl/counter_4bit.sv
// Free-running up-counter that wraps after MAX_VALUE. It has a combinational
// terminal-count flag and a registered wrap pulse, so counters can be chained.
// MAX_VALUE must lie in 1..2**WIDTH-1. Count values above MAX_VALUE are never
// reached, because the wrap compare is an exact match on MAX_VALUE.
module counter_4bit #(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 2**WIDTH - 1
) (
  input  logic          clk,
  input  logic          reset,   // async, active-low
  counter_4bit_if.slave cnt_if
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_max;

  assign at_max = (count_q == MAX_V);

  // Next-state: advance when enabled, and roll to zero at MAX_VALUE with a wrap pulse.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (cnt_if.enable) begin
      if (at_max) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // State register: reset clears count and wrap immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cnt_if.count = count_q;
  assign cnt_if.wrap  = wrap_q;
  assign cnt_if.tc    = at_max & cnt_if.enable;

endmodule

// File: tb/tb_counter_4bit.sv
module tb_counter_4bit;

  localparam int M16 = 15;
  localparam int M9  = 9;

  logic clk;
  logic reset;

  counter_4bit_if #(.WIDTH(4)) if16 ();
  counter_4bit_if #(.WIDTH(4)) if9 ();

  counter_4bit #(.WIDTH(4)) dut16 (
    .clk    (clk),
    .reset  (reset),
    .cnt_if (if16.slave)
  );

  counter_4bit #(.WIDTH(4), .MAX_VALUE(M9)) dut9 (
    .clk    (clk),
    .reset  (reset),
    .cnt_if (if9.slave)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int c16 = 0, c9 = 0;
  int w16 = 0, w9 = 0;
  int en  = 0;
  int wrap9_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_en(input int v);
    en = v;
    if16.enable = (v != 0);
    if9.enable  = (v != 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " count16"}, int'(if16.count), c16);
    chk({tag, " wrap16"},  int'(if16.wrap),  w16);
    chk({tag, " tc16"},    int'(if16.tc),    (c16 == M16 && en != 0) ? 1 : 0);
    chk({tag, " count9"},  int'(if9.count),  c9);
    chk({tag, " wrap9"},   int'(if9.wrap),   w9);
    chk({tag, " tc9"},     int'(if9.tc),     (c9 == M9 && en != 0) ? 1 : 0);
  endtask

  // One rising edge: advance the model, then sample the outputs 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    if (reset) begin
      w16 = (en != 0 && c16 == M16) ? 1 : 0;
      w9  = (en != 0 && c9  == M9)  ? 1 : 0;
      if (en != 0) begin
        c16 = (c16 + 1) % (M16 + 1);
        c9  = (c9  + 1) % (M9  + 1);
      end
    end else begin
      c16 = 0; c9 = 0; w16 = 0; w9 = 0;
    end
    #1;
    check_all(tag);
  endtask

  // Pull reset low between edges; the outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    c16 = 0; c9 = 0; w16 = 0; w9 = 0;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    set_en(0);
    #2 reset = 1'b0;
    #1 check_all("rst_hold");
    #9 reset = 1'b1;                 // low from 2 ns to 12 ns
    check_all("rst_rel");
    step("idle0");
    step("idle1");

    // continuous count with wrap, and the MAX_VALUE=9 variant alongside it
    set_en(1);
    wrap9_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step("run");
      if (i < 12) wrap9_seen += int'(if9.wrap);
      if (i == 11) chk("var9_after12", int'(if9.count), 2);
      if (i == 15) chk("wrap_edge16", int'(if16.count), 0);
    end
    chk("var9_wraps", wrap9_seen, 1);
    chk("run20_count", int'(if16.count), 4);

    // pause, then resume
    set_en(0);
    for (int i = 0; i < 3; i++) step("pause");
    chk("pause_hold", int'(if16.count), 4);
    set_en(1);
    for (int i = 0; i < 5; i++) step("resume");
    chk("resume_count", int'(if16.count), 9);

    // asynchronous reset mid-run
    async_reset("async_rst");
    // reset has priority over enable
    for (int i = 0; i < 3; i++) step("rst_prio");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step("restart");
    chk("restart_count", int'(if16.count), 5);

    // randomized enable with occasional async resets
    for (int i = 0; i < 400; i++) begin
      set_en(($urandom_range(0, 3) != 0) ? 1 : 0);
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rnd_async");
        step("rnd_inrst");
        reset = 1'b1;
      end else begin
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
